ysyx_25040111_axi_arbiter: RTL and testbench
============================================

// Module: ysyx_25040111_axi_arbiter
// PURPOSE
//  Shares the core's single AXI4 master port between the IFU (read-only) and the LSU (read+write).
//  Grants one owner per transaction, locks the grant from the address handshake to the last
//  response handshake, and routes the response back to the owner. Sits between IFU/LSU and the
//  io_master_* / SRAM side. Single-beat only: len=0, burst=0, id=0 driven downstream.
// PARAMETERS
//  TIMEOUT_CYC  0   cycles a grant may stay open before 'timeout' sets; 0 disables the watchdog
//  TO_W         16  width of the watchdog counter; TIMEOUT_CYC must fit in TO_W bits
// PORTS
//  clk          in   1   single clock; all state on posedge
//  reset        in   1   asynchronous, active-high reset
//  ifu_ar{valid,ready,addr}   in,out,in   1,1,32   IFU read address; size fixed 3'b010
//  ifu_r{valid,ready,data,resp}  out,in,out,out  1,1,32,2   IFU read response
//  lsu_ar{valid,ready,addr,size} in,out,in,in  1,1,32,3   LSU read address
//  lsu_r{valid,ready,data,resp}  out,in,out,out  1,1,32,2   LSU read response
//  lsu_aw{valid,ready,addr,size} in,out,in,in  1,1,32,3   LSU write address
//  lsu_w{valid,ready,data,strb,last} in,out,in,in,in  1,1,32,4,1   LSU write data
//  lsu_b{valid,ready,resp}    out,in,out   1,1,2   LSU write response
//  mem_*        mirror of all the above channels toward downstream; directions reversed
//  busy         out  1   a grant is open (state != IDLE)
//  timeout      out  1   sticky: the watchdog expired; cleared only by reset
// BEHAVIOUR
//  States: IDLE, IFU_RD, LSU_RD, LSU_WR.
//   - IDLE: samples requests (ifu_arvalid, lsu_arvalid, lsu_awvalid).
//     Next state is registered, giving a 1-cycle arbitration bubble.
//   - LSU_WR beats LSU_RD if the LSU raises both.
//   - IFU vs LSU when both request: round-robin. last_owner resets to IFU, so LSU wins the first conflict.
//  IFU_RD / LSU_RD:
//   - Owner's ar* connects to mem_ar* combinationally; mem_r* goes to the owner's r*.
//   - On mem_rvalid & owner rready: return to IDLE and update last_owner.
//  LSU_WR:
//   - aw*, w* and b* connect combinationally.
//   - AW and W may complete in the same cycle or in either order.
//   - Returns to IDLE on mem_bvalid & lsu_bready.
//  Non-owners:
//   - See *ready=0 and *valid=0.
//   - A request held by a non-owner stays pending; it is never dropped or acked.
//  In IDLE:
//   - All mem_*valid=0 and mem_rready=mem_bready=0.
//   - No upstream ready is asserted.
//  Protocol checks:
//   - mem_ar* must be stable while mem_arvalid & !mem_arready. The arbiter never changes owner mid-handshake.
//   - An upstream AR accepted while already granted is illegal. Owners issue one outstanding transaction.
//  Watchdog:
//   - Counter clears on entry to any grant state and increments each cycle while not IDLE.
//   - At TIMEOUT_CYC, 'timeout' sets. The grant is still held; there is no forced abort.
//   - The counter saturates at its maximum.
//  Responses: rresp/bresp pass through unmodified. Error handling belongs to the owner.
//  Reset:
//   - Asynchronous; may hit mid-transaction.
//   - Values: state=IDLE, last_owner=IFU, counter=0, timeout=0, busy=0.
//   - Upstream and downstream valid/ready all 0 immediately; an in-flight transfer is abandoned.
//  Combinational paths: data/addr/strb are muxes keyed on the registered state only. No request-to-grant comb path.
// TESTING
//  1. IFU AR 0x8000_0000 alone:
//     - IDLE->IFU_RD in 1 cycle; mem_araddr=0x8000_0000, mem_arsize=2.
//     - mem_rdata 0x1234_5678 reaches ifu_rdata; then IDLE.
//  2. IFU and LSU AR in the same cycle after reset:
//     - LSU granted first.
//     - On the next simultaneous pair IFU wins; strictly alternates under a continuous load.
//  3. LSU write 0xDEAD_BEEF, strb 4'b1100, with W before AW and B delayed 5 cycles:
//     - busy stays 1 throughout.
//     - lsu_bresp=0 is delivered; the IFU request waits and is granted afterwards.
//  4. LSU read with mem_rresp=2'b10:
//     - lsu_rresp=2'b10 is passed through.
//     - Arbiter returns to IDLE normally.
//  5. TIMEOUT_CYC=8 with the downstream never answering:
//     - timeout=1 exactly 8 cycles after grant entry and stays 1.
//     - Reset clears it and returns to IDLE.
//  6. Reset asserted mid-LSU_WR: all valid/ready drop asynchronously; after release, a new IFU read completes.

Source files
------------

// File: rtl/ysyx_25040111_axi_arbiter.sv
// Two-master single-beat AXI4 arbiter: IFU (read) and LSU (read/write) share one downstream port.
// The grant is locked from the address handshake until the final response, with a sticky watchdog flag.
module ysyx_25040111_axi_arbiter #(
    parameter int TIMEOUT_CYC = 0,
    parameter int TO_W        = 16
) (
    input  logic        clk,
    input  logic        reset,
    // IFU read
    input  logic        ifu_arvalid_i,
    output logic        ifu_arready_o,
    input  logic [31:0] ifu_araddr_i,
    output logic        ifu_rvalid_o,
    input  logic        ifu_rready_i,
    output logic [31:0] ifu_rdata_o,
    output logic [1:0]  ifu_rresp_o,
    // LSU read
    input  logic        lsu_arvalid_i,
    output logic        lsu_arready_o,
    input  logic [31:0] lsu_araddr_i,
    input  logic [2:0]  lsu_arsize_i,
    output logic        lsu_rvalid_o,
    input  logic        lsu_rready_i,
    output logic [31:0] lsu_rdata_o,
    output logic [1:0]  lsu_rresp_o,
    // LSU write
    input  logic        lsu_awvalid_i,
    output logic        lsu_awready_o,
    input  logic [31:0] lsu_awaddr_i,
    input  logic [2:0]  lsu_awsize_i,
    input  logic        lsu_wvalid_i,
    output logic        lsu_wready_o,
    input  logic [31:0] lsu_wdata_i,
    input  logic [3:0]  lsu_wstrb_i,
    input  logic        lsu_wlast_i,
    output logic        lsu_bvalid_o,
    input  logic        lsu_bready_i,
    output logic [1:0]  lsu_bresp_o,
    // Downstream
    output logic        mem_arvalid_o,
    input  logic        mem_arready_i,
    output logic [31:0] mem_araddr_o,
    output logic [2:0]  mem_arsize_o,
    output logic [7:0]  mem_arlen_o,
    output logic [1:0]  mem_arburst_o,
    output logic [3:0]  mem_arid_o,
    input  logic        mem_rvalid_i,
    output logic        mem_rready_o,
    input  logic [31:0] mem_rdata_i,
    input  logic [1:0]  mem_rresp_i,
    output logic        mem_awvalid_o,
    input  logic        mem_awready_i,
    output logic [31:0] mem_awaddr_o,
    output logic [2:0]  mem_awsize_o,
    output logic [7:0]  mem_awlen_o,
    output logic [1:0]  mem_awburst_o,
    output logic [3:0]  mem_awid_o,
    output logic        mem_wvalid_o,
    input  logic        mem_wready_i,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wstrb_o,
    output logic        mem_wlast_o,
    input  logic        mem_bvalid_i,
    output logic        mem_bready_o,
    input  logic [1:0]  mem_bresp_i,
    // Status
    output logic        busy_o,
    output logic        timeout_o
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_IFU_RD = 2'd1;
    localparam logic [1:0] S_LSU_RD = 2'd2;
    localparam logic [1:0] S_LSU_WR = 2'd3;

    localparam logic OWNER_IFU = 1'b0;
    localparam logic OWNER_LSU = 1'b1;

    localparam bit              TO_EN   = (TIMEOUT_CYC != 0);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    logic [1:0]      state_q, state_d;
    logic            last_owner_q, last_owner_d;
    logic            ar_done_q, ar_done_d;
    logic            aw_done_q, aw_done_d;
    logic            w_done_q, w_done_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            timeout_q, timeout_d;

    logic in_ifu_rd, in_lsu_rd, in_lsu_wr;

    assign in_ifu_rd = (state_q == S_IFU_RD);
    assign in_lsu_rd = (state_q == S_LSU_RD);
    assign in_lsu_wr = (state_q == S_LSU_WR);

    // Routing depends only on registered state, so no request can reach a grant combinationally.
    assign mem_arvalid_o = !ar_done_q && ((in_ifu_rd && ifu_arvalid_i) || (in_lsu_rd && lsu_arvalid_i));
    assign ifu_arready_o = in_ifu_rd && !ar_done_q && mem_arready_i;
    assign lsu_arready_o = in_lsu_rd && !ar_done_q && mem_arready_i;
    assign mem_araddr_o  = in_lsu_rd ? lsu_araddr_i : ifu_araddr_i;
    assign mem_arsize_o  = in_lsu_rd ? lsu_arsize_i : 3'b010;
    assign mem_arlen_o   = 8'd0;
    assign mem_arburst_o = 2'b00;
    assign mem_arid_o    = 4'd0;

    assign mem_rready_o  = (in_ifu_rd && ifu_rready_i) || (in_lsu_rd && lsu_rready_i);
    assign ifu_rvalid_o  = in_ifu_rd && mem_rvalid_i;
    assign lsu_rvalid_o  = in_lsu_rd && mem_rvalid_i;
    assign ifu_rdata_o   = mem_rdata_i;
    assign ifu_rresp_o   = mem_rresp_i;
    assign lsu_rdata_o   = mem_rdata_i;
    assign lsu_rresp_o   = mem_rresp_i;

    assign mem_awvalid_o = in_lsu_wr && !aw_done_q && lsu_awvalid_i;
    assign lsu_awready_o = in_lsu_wr && !aw_done_q && mem_awready_i;
    assign mem_awaddr_o  = lsu_awaddr_i;
    assign mem_awsize_o  = lsu_awsize_i;
    assign mem_awlen_o   = 8'd0;
    assign mem_awburst_o = 2'b00;
    assign mem_awid_o    = 4'd0;

    assign mem_wvalid_o  = in_lsu_wr && !w_done_q && lsu_wvalid_i;
    assign lsu_wready_o  = in_lsu_wr && !w_done_q && mem_wready_i;
    assign mem_wdata_o   = lsu_wdata_i;
    assign mem_wstrb_o   = lsu_wstrb_i;
    assign mem_wlast_o   = lsu_wlast_i;

    assign mem_bready_o  = in_lsu_wr && lsu_bready_i;
    assign lsu_bvalid_o  = in_lsu_wr && mem_bvalid_i;
    assign lsu_bresp_o   = mem_bresp_i;

    assign busy_o    = (state_q != S_IDLE);
    assign timeout_o = timeout_q;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path through the case infers a latch.
        state_d      = state_q;
        last_owner_d = last_owner_q;
        ar_done_d    = ar_done_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        cnt_d        = cnt_q;
        timeout_d    = timeout_q;

        case (state_q)
            S_IDLE: begin
                ar_done_d = 1'b0;
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                cnt_d     = '0;
                if ((lsu_awvalid_i || lsu_arvalid_i) && (!ifu_arvalid_i || last_owner_q == OWNER_IFU)) begin
                    state_d = lsu_awvalid_i ? S_LSU_WR : S_LSU_RD;
                end else if (ifu_arvalid_i) begin
                    state_d = S_IFU_RD;
                end
            end
            S_IFU_RD, S_LSU_RD: begin
                if (mem_arvalid_o && mem_arready_i) ar_done_d = 1'b1;
                if (mem_rvalid_i && mem_rready_o) begin
                    state_d      = S_IDLE;
                    last_owner_d = in_lsu_rd ? OWNER_LSU : OWNER_IFU;
                end
            end
            default: begin
                if (mem_awvalid_o && mem_awready_i) aw_done_d = 1'b1;
                if (mem_wvalid_o && mem_wready_i)   w_done_d  = 1'b1;
                if (mem_bvalid_i && mem_bready_o) begin
                    state_d      = S_IDLE;
                    last_owner_d = OWNER_LSU;
                end
            end
        endcase

        if (state_q != S_IDLE) begin
            if (cnt_q != '1) cnt_d = cnt_q + TO_W'(1);
            if (TO_EN && cnt_q >= TO_LAST) timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state is updated with non-blocking assignments so all registers sample together.
        if (reset) begin
            state_q      <= S_IDLE;
            last_owner_q <= OWNER_IFU;
            ar_done_q    <= 1'b0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            cnt_q        <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            ar_done_q    <= ar_done_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            cnt_q        <= cnt_d;
            timeout_q    <= timeout_d;
        end
    end

endmodule

// File: tb/tb_ysyx_25040111_axi_arbiter.sv
// Directed bench for the IFU/LSU AXI arbiter: single reads, round-robin, split write, error pass-through,
// watchdog and asynchronous reset.
module tb_ysyx_25040111_axi_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready;
    logic [31:0] ifu_araddr, ifu_rdata;
    logic [1:0]  ifu_rresp;
    logic        lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready;
    logic [31:0] lsu_araddr, lsu_rdata;
    logic [2:0]  lsu_arsize;
    logic [1:0]  lsu_rresp;
    logic        lsu_awvalid, lsu_awready, lsu_wvalid, lsu_wready, lsu_wlast, lsu_bvalid, lsu_bready;
    logic [31:0] lsu_awaddr, lsu_wdata;
    logic [2:0]  lsu_awsize;
    logic [3:0]  lsu_wstrb;
    logic [1:0]  lsu_bresp;
    logic        mem_arvalid, mem_arready, mem_rvalid, mem_rready;
    logic [31:0] mem_araddr, mem_rdata;
    logic [2:0]  mem_arsize;
    logic [7:0]  mem_arlen;
    logic [1:0]  mem_arburst, mem_rresp;
    logic [3:0]  mem_arid;
    logic        mem_awvalid, mem_awready, mem_wvalid, mem_wready, mem_wlast, mem_bvalid, mem_bready;
    logic [31:0] mem_awaddr, mem_wdata;
    logic [2:0]  mem_awsize;
    logic [7:0]  mem_awlen;
    logic [1:0]  mem_awburst, mem_bresp;
    logic [3:0]  mem_awid, mem_wstrb;
    logic        busy, timeout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ysyx_25040111_axi_arbiter #(.TIMEOUT_CYC(8), .TO_W(16)) dut (
        .clk(clk), .reset(reset),
        .ifu_arvalid_i(ifu_arvalid), .ifu_arready_o(ifu_arready), .ifu_araddr_i(ifu_araddr),
        .ifu_rvalid_o(ifu_rvalid), .ifu_rready_i(ifu_rready), .ifu_rdata_o(ifu_rdata), .ifu_rresp_o(ifu_rresp),
        .lsu_arvalid_i(lsu_arvalid), .lsu_arready_o(lsu_arready), .lsu_araddr_i(lsu_araddr),
        .lsu_arsize_i(lsu_arsize), .lsu_rvalid_o(lsu_rvalid), .lsu_rready_i(lsu_rready),
        .lsu_rdata_o(lsu_rdata), .lsu_rresp_o(lsu_rresp),
        .lsu_awvalid_i(lsu_awvalid), .lsu_awready_o(lsu_awready), .lsu_awaddr_i(lsu_awaddr),
        .lsu_awsize_i(lsu_awsize), .lsu_wvalid_i(lsu_wvalid), .lsu_wready_o(lsu_wready),
        .lsu_wdata_i(lsu_wdata), .lsu_wstrb_i(lsu_wstrb), .lsu_wlast_i(lsu_wlast),
        .lsu_bvalid_o(lsu_bvalid), .lsu_bready_i(lsu_bready), .lsu_bresp_o(lsu_bresp),
        .mem_arvalid_o(mem_arvalid), .mem_arready_i(mem_arready), .mem_araddr_o(mem_araddr),
        .mem_arsize_o(mem_arsize), .mem_arlen_o(mem_arlen), .mem_arburst_o(mem_arburst), .mem_arid_o(mem_arid),
        .mem_rvalid_i(mem_rvalid), .mem_rready_o(mem_rready), .mem_rdata_i(mem_rdata), .mem_rresp_i(mem_rresp),
        .mem_awvalid_o(mem_awvalid), .mem_awready_i(mem_awready), .mem_awaddr_o(mem_awaddr),
        .mem_awsize_o(mem_awsize), .mem_awlen_o(mem_awlen), .mem_awburst_o(mem_awburst), .mem_awid_o(mem_awid),
        .mem_wvalid_o(mem_wvalid), .mem_wready_i(mem_wready), .mem_wdata_o(mem_wdata),
        .mem_wstrb_o(mem_wstrb), .mem_wlast_o(mem_wlast),
        .mem_bvalid_i(mem_bvalid), .mem_bready_o(mem_bready), .mem_bresp_i(mem_bresp),
        .busy_o(busy), .timeout_o(timeout)
    );

    task automatic clear_inputs();
        ifu_arvalid = 0; ifu_araddr = '0; ifu_rready = 0;
        lsu_arvalid = 0; lsu_araddr = '0; lsu_arsize = '0; lsu_rready = 0;
        lsu_awvalid = 0; lsu_awaddr = '0; lsu_awsize = '0;
        lsu_wvalid = 0; lsu_wdata = '0; lsu_wstrb = '0; lsu_wlast = 0; lsu_bready = 0;
        mem_arready = 0; mem_rvalid = 0; mem_rdata = '0; mem_rresp = '0;
        mem_awready = 0; mem_wready = 0; mem_bvalid = 0; mem_bresp = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        ifu_arvalid = 1; lsu_awvalid = 1; lsu_wvalid = 1; mem_arready = 1; mem_awready = 1;
        tick(); tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
        checks++; if ({mem_arvalid, mem_awvalid, mem_wvalid, mem_rready, mem_bready} !== 5'b0) begin
            errors++; $display("FAIL reset_mem_handshake: got %b expected 00000",
                               {mem_arvalid, mem_awvalid, mem_wvalid, mem_rready, mem_bready}); end
        checks++; if ({ifu_arready, lsu_awready, lsu_wready} !== 3'b0) begin
            errors++; $display("FAIL reset_up_ready: got %b expected 000", {ifu_arready, lsu_awready, lsu_wready}); end
        apply_reset();
    endtask

    task automatic test_ifu_read();
        apply_reset();
        ifu_arvalid = 1; ifu_araddr = 32'h8000_0000; ifu_rready = 1; mem_arready = 1;
        #1;
        checks++; if ({busy, mem_arvalid, ifu_arready} !== 3'b000) begin
            errors++; $display("FAIL ifu_idle_bubble: got %b expected 000", {busy, mem_arvalid, ifu_arready}); end
        tick();
        checks++; if ({busy, mem_arvalid, ifu_arready} !== 3'b111) begin
            errors++; $display("FAIL ifu_grant: got %b expected 111", {busy, mem_arvalid, ifu_arready}); end
        checks++; if (mem_araddr !== 32'h8000_0000) begin
            errors++; $display("FAIL ifu_araddr: got %h expected 80000000", mem_araddr); end
        checks++; if ({mem_arsize, mem_arlen, mem_arburst, mem_arid} !== {3'd2, 8'd0, 2'd0, 4'd0}) begin
            errors++; $display("FAIL ifu_ar_attrs: size %0d len %0d burst %0d id %0d expected 2/0/0/0",
                               mem_arsize, mem_arlen, mem_arburst, mem_arid); end
        tick();
        ifu_arvalid = 0; mem_arready = 0;
        mem_rvalid = 1; mem_rdata = 32'h1234_5678; mem_rresp = 2'b00;
        #1;
        checks++; if ({ifu_rvalid, mem_rready} !== 2'b11) begin
            errors++; $display("FAIL ifu_rvalid: got %b expected 11", {ifu_rvalid, mem_rready}); end
        checks++; if (ifu_rdata !== 32'h1234_5678) begin
            errors++; $display("FAIL ifu_rdata: got %h expected 12345678", ifu_rdata); end
        tick();
        mem_rvalid = 0;
        #1;
        checks++; if ({busy, mem_rready} !== 2'b00) begin
            errors++; $display("FAIL ifu_back_idle: got %b expected 00", {busy, mem_rready}); end
    endtask

    task automatic test_round_robin();
        logic want_lsu;
        apply_reset();
        want_lsu = 1'b1;
        ifu_arvalid = 1; ifu_araddr = 32'h8000_0100; ifu_rready = 1;
        lsu_arvalid = 1; lsu_araddr = 32'h0000_2000; lsu_arsize = 3'b010; lsu_rready = 1;
        for (int r = 0; r < 4; r++) begin
            tick();
            mem_arready = 1;
            #1;
            checks++; if (mem_araddr !== (want_lsu ? 32'h0000_2000 : 32'h8000_0100)) begin
                errors++; $display("FAIL rr_addr round %0d: got %h expected %h", r, mem_araddr,
                                   want_lsu ? 32'h0000_2000 : 32'h8000_0100); end
            checks++; if ({lsu_arready, ifu_arready} !== {want_lsu, !want_lsu}) begin
                errors++; $display("FAIL rr_ready round %0d: got lsu/ifu %b expected %b", r,
                                   {lsu_arready, ifu_arready}, {want_lsu, !want_lsu}); end
            tick();
            mem_arready = 0;
            if (want_lsu) lsu_arvalid = 0; else ifu_arvalid = 0;
            mem_rvalid = 1; mem_rdata = 32'h100 + r;
            #1;
            checks++; if ({lsu_rvalid, ifu_rvalid} !== {want_lsu, !want_lsu}) begin
                errors++; $display("FAIL rr_rvalid round %0d: got lsu/ifu %b expected %b", r,
                                   {lsu_rvalid, ifu_rvalid}, {want_lsu, !want_lsu}); end
            tick();
            mem_rvalid = 0; lsu_arvalid = 1; ifu_arvalid = 1;
            #1;
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_idle round %0d: got %b expected 0", r, busy); end
            want_lsu = !want_lsu;
        end
    endtask

    task automatic test_write_split();
        apply_reset();
        lsu_awvalid = 1; lsu_awaddr = 32'h3000_0010; lsu_awsize = 3'b010;
        lsu_wvalid = 1; lsu_wdata = 32'hDEAD_BEEF; lsu_wstrb = 4'b1100; lsu_wlast = 1; lsu_bready = 1;
        ifu_arvalid = 1; ifu_araddr = 32'h8000_0200; ifu_rready = 1;
        tick();
        mem_wready = 1;
        #1;
        checks++; if ({mem_wvalid, lsu_wready, mem_awvalid, lsu_awready} !== 4'b1110) begin
            errors++; $display("FAIL wr_w_first: got %b expected 1110", {mem_wvalid, lsu_wready, mem_awvalid, lsu_awready}); end
        checks++; if ({mem_wdata, mem_wstrb, mem_wlast} !== {32'hDEAD_BEEF, 4'b1100, 1'b1}) begin
            errors++; $display("FAIL wr_wdata: got %h/%b expected deadbeef/1100", mem_wdata, mem_wstrb); end
        checks++; if ({mem_arvalid, ifu_arready} !== 2'b00) begin
            errors++; $display("FAIL wr_ifu_blocked: got %b expected 00", {mem_arvalid, ifu_arready}); end
        tick();
        lsu_wvalid = 0; mem_wready = 0; mem_awready = 1;
        #1;
        checks++; if ({lsu_awready, mem_awvalid} !== 2'b11 || mem_awaddr !== 32'h3000_0010) begin
            errors++; $display("FAIL wr_aw: got ready/valid %b addr %h expected 11 30000010",
                               {lsu_awready, mem_awvalid}, mem_awaddr); end
        tick();
        lsu_awvalid = 0; mem_awready = 0;
        for (int i = 0; i < 5; i++) begin
            checks++; if ({busy, lsu_bvalid, mem_bready} !== 3'b101) begin
                errors++; $display("FAIL wr_b_wait %0d: got %b expected 101", i, {busy, lsu_bvalid, mem_bready}); end
            tick();
        end
        mem_bvalid = 1; mem_bresp = 2'b00;
        #1;
        checks++; if ({lsu_bvalid, lsu_bresp, busy} !== 4'b1001) begin
            errors++; $display("FAIL wr_bresp: got %b expected 1001", {lsu_bvalid, lsu_bresp, busy}); end
        tick();
        mem_bvalid = 0;
        #1;
        checks++; if ({busy, ifu_arready} !== 2'b00) begin
            errors++; $display("FAIL wr_done_idle: got %b expected 00", {busy, ifu_arready}); end
        tick();
        checks++; if ({busy, mem_arvalid} !== 2'b11 || mem_araddr !== 32'h8000_0200) begin
            errors++; $display("FAIL wr_ifu_after: got %b addr %h expected 11 80000200", {busy, mem_arvalid}, mem_araddr); end
        mem_arready = 1;
        tick();
        ifu_arvalid = 0; mem_arready = 0; mem_rvalid = 1; mem_rdata = 32'h0BAD_F00D;
        tick();
        mem_rvalid = 0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_ifu_done: got %b expected 0", busy); end
    endtask

    task automatic test_read_error();
        apply_reset();
        lsu_arvalid = 1; lsu_araddr = 32'h0000_4000; lsu_arsize = 3'b000; lsu_rready = 1;
        tick();
        mem_arready = 1;
        #1;
        checks++; if ({lsu_arready, mem_arsize} !== {1'b1, 3'b000}) begin
            errors++; $display("FAIL rderr_ar: got %b expected 1000", {lsu_arready, mem_arsize}); end
        tick();
        lsu_arvalid = 0; mem_arready = 0; mem_rvalid = 1; mem_rresp = 2'b10; mem_rdata = 32'h5A5A_0000;
        #1;
        checks++; if ({lsu_rvalid, lsu_rresp} !== 3'b110) begin
            errors++; $display("FAIL rderr_resp: got %b expected 110", {lsu_rvalid, lsu_rresp}); end
        tick();
        mem_rvalid = 0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rderr_idle: got %b expected 0", busy); end
    endtask

    task automatic test_timeout();
        apply_reset();
        ifu_arvalid = 1; ifu_araddr = 32'h8000_0300; ifu_rready = 1;
        tick();
        checks++; if ({busy, timeout} !== 2'b10) begin
            errors++; $display("FAIL to_entry: got %b expected 10", {busy, timeout}); end
        for (int i = 1; i < 8; i++) begin
            tick();
            checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_early cycle %0d: got 1 expected 0", i); end
        end
        tick();
        checks++; if ({busy, timeout} !== 2'b11) begin
            errors++; $display("FAIL to_set: got %b expected 11", {busy, timeout}); end
        repeat (3) tick();
        checks++; if ({busy, timeout, mem_arvalid} !== 3'b111) begin
            errors++; $display("FAIL to_sticky: got %b expected 111", {busy, timeout, mem_arvalid}); end
        reset = 1'b1;
        #1;
        checks++; if ({busy, timeout, mem_arvalid, ifu_arready} !== 4'b0000) begin
            errors++; $display("FAIL to_reset: got %b expected 0000", {busy, timeout, mem_arvalid, ifu_arready}); end
        clear_inputs();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset_mid_write();
        apply_reset();
        lsu_awvalid = 1; lsu_awaddr = 32'h3000_0020; lsu_wvalid = 1; lsu_wdata = 32'h1111_2222;
        lsu_wstrb = 4'b1111; lsu_wlast = 1; lsu_bready = 1;
        tick();
        mem_awready = 1; mem_wready = 1;
        #1;
        checks++; if ({mem_awvalid, mem_wvalid, lsu_awready, lsu_wready, mem_bready} !== 5'b11111) begin
            errors++; $display("FAIL rst_mid_pre: got %b expected 11111",
                               {mem_awvalid, mem_wvalid, lsu_awready, lsu_wready, mem_bready}); end
        #1 reset = 1'b1;
        #1;
        checks++; if ({mem_awvalid, mem_wvalid, lsu_awready, lsu_wready, mem_bready, busy} !== 6'b0) begin
            errors++; $display("FAIL rst_mid_drop: got %b expected 000000",
                               {mem_awvalid, mem_wvalid, lsu_awready, lsu_wready, mem_bready, busy}); end
        clear_inputs();
        tick();
        #1 reset = 1'b0;
        ifu_arvalid = 1; ifu_araddr = 32'h8000_0400; ifu_rready = 1;
        tick();
        mem_arready = 1;
        #1;
        checks++; if ({ifu_arready, mem_araddr} !== {1'b1, 32'h8000_0400}) begin
            errors++; $display("FAIL rst_mid_ifu_ar: got %b %h expected 1 80000400", ifu_arready, mem_araddr); end
        tick();
        ifu_arvalid = 0; mem_arready = 0; mem_rvalid = 1; mem_rdata = 32'hCAFE_F00D;
        #1;
        checks++; if ({ifu_rvalid, ifu_rdata} !== {1'b1, 32'hCAFE_F00D}) begin
            errors++; $display("FAIL rst_mid_ifu_r: got %b %h expected 1 cafef00d", ifu_rvalid, ifu_rdata); end
        tick();
        mem_rvalid = 0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_idle: got %b expected 0", busy); end
    endtask

    initial begin
        test_reset();
        test_ifu_read();
        test_round_robin();
        test_write_split();
        test_read_error();
        test_timeout();
        test_reset_mid_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit: simulation still running at %0t, expected to finish earlier", $time);
        $fatal(1, "time limit");
    end

endmodule
